// File: rtl/bip_program_loader_pkg.sv
// Shared BIP definitions: instruction field layout, the HLT opcode, default
// memory geometry, and the program-loader state encoding.
package bip_program_loader_pkg;

  localparam int ADDR_WIDTH_DEF = 11;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int OPCODE_WIDTH   = 5;

  localparam logic [OPCODE_WIDTH-1:0] HLT_OPCODE = 5'b00000;

  localparam logic [2:0] LD_IDLE    = 3'd0;
  localparam logic [2:0] LD_WAIT_HI = 3'd1;
  localparam logic [2:0] LD_WAIT_LO = 3'd2;
  localparam logic [2:0] LD_WRITE   = 3'd3;
  localparam logic [2:0] LD_RUN     = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = LD_IDLE,
    ST_WAIT_HI = LD_WAIT_HI,
    ST_WAIT_LO = LD_WAIT_LO,
    ST_WRITE   = LD_WRITE,
    ST_RUN     = LD_RUN
  } ld_state_e;

endpackage

// File: rtl/bip_program_loader_if.sv
// Byte stream in from the UART receiver and word write bus out to program
// memory. Handshake: i_rx_valid is a one-cycle strobe with no back-pressure
// (a byte is taken on every clock edge where it is high); o_mem_we is the only
// qualifier of o_mem_addr/o_mem_data and is high for exactly one cycle per word.
interface bip_program_loader_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] o_mem_data;
  logic                  o_mem_we;

  // Byte source / memory sink side.
  modport master (
    output i_rx_data, i_rx_valid,
    input  o_mem_addr, o_mem_data, o_mem_we
  );

  // Loader side.
  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_mem_addr, o_mem_data, o_mem_we
  );
endinterface

// File: rtl/bip_program_loader.sv
// BIP program loader: assembles big-endian 16-bit words from received bytes,
// writes them to consecutive program-memory addresses from 0, and holds the
// CPU in reset until HLT has been written or memory is full.
module bip_program_loader
  import bip_program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  bip_program_loader_if.slave   bus,
  output logic                  o_cpu_rst,
  output logic                  o_loaded,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_overrun,
  output ld_state_e             o_dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  ld_state_e             state_q, state_d;
  logic [7:0]            hi_byte_q, hi_byte_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic                  mem_we_q, mem_we_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  loaded_q, loaded_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic                  overrun_q, overrun_d;
  logic                  restart;
  logic                  last_word;

  // The load ends on HLT or after writing the top address.
  assign last_word = (mem_data_q[DATA_WIDTH-1 -: OPCODE_WIDTH] == HLT_OPCODE) ||
                     (mem_addr_q == '1);

  // Next-state and datapath; i_start takes priority over any byte strobe.
  always_comb begin
    state_d      = state_q;
    hi_byte_d    = hi_byte_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_we_d     = 1'b0;
    cpu_rst_d    = cpu_rst_q;
    loaded_d     = loaded_q;
    word_count_d = word_count_q;
    overrun_d    = overrun_q;
    restart      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start) restart = 1'b1;
      end
      ST_WAIT_HI: begin
        if (i_start) begin
          restart = 1'b1;
        end else if (bus.i_rx_valid) begin
          hi_byte_d = bus.i_rx_data;
          state_d   = ST_WAIT_LO;
        end
      end
      ST_WAIT_LO: begin
        if (i_start) begin
          restart = 1'b1;
        end else if (bus.i_rx_valid) begin
          mem_data_d = {hi_byte_q, bus.i_rx_data};
          mem_we_d   = 1'b1;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (i_start) begin
          restart = 1'b1;
        end else begin
          word_count_d = word_count_q + CNT_ONE;
          // No buffering: a byte arriving during the write cycle is lost.
          if (bus.i_rx_valid) overrun_d = 1'b1;
          if (last_word) begin
            state_d   = ST_RUN;
            cpu_rst_d = 1'b1;
            loaded_d  = 1'b1;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
            state_d    = ST_WAIT_HI;
          end
        end
      end
      ST_RUN: begin
        if (i_start) restart = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d      = ST_WAIT_HI;
      hi_byte_d    = '0;
      mem_addr_d   = '0;
      mem_we_d     = 1'b0;
      cpu_rst_d    = 1'b0;
      loaded_d     = 1'b0;
      word_count_d = '0;
      overrun_d    = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      hi_byte_q    <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_we_q     <= 1'b0;
      cpu_rst_q    <= 1'b0;
      loaded_q     <= 1'b0;
      word_count_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_byte_q    <= hi_byte_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_we_q     <= mem_we_d;
      cpu_rst_q    <= cpu_rst_d;
      loaded_q     <= loaded_d;
      word_count_q <= word_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.o_mem_addr = mem_addr_q;
  assign bus.o_mem_data = mem_data_q;
  assign bus.o_mem_we   = mem_we_q;
  assign o_cpu_rst      = cpu_rst_q;
  assign o_loaded       = loaded_q;
  assign o_word_count   = word_count_q;
  assign o_overrun      = overrun_q;
  assign o_dbg_state    = state_q;

endmodule

// File: doc/bip_program_loader.md
Name: bip_program_loader

Overview:
- Writer side of the BIP program-memory interface. The control unit only fetches instructions by address; this block fills that memory.
- Takes a byte stream from the UART receiver and assembles big-endian 16-bit instruction words.
- Writes each word to consecutive program-memory addresses from 0.
- Holds the CPU in reset while loading. Releases it once the HLT word (opcode 5'b00000) has been written, or once memory is full.

Parameters:
- ADDR_WIDTH, 11, program-memory address width; memory depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 16, instruction width; fixed at 2 bytes per word.
- OPCODE_WIDTH, 5, opcode field width, located at [DATA_WIDTH-1 -: OPCODE_WIDTH].
- HLT_OPCODE, 5'b00000, opcode that terminates the load.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- i_start  in  1  one-cycle pulse; begins or restarts a program load
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid
- o_mem_addr  out  ADDR_WIDTH  program-memory write address
- o_mem_data  out  DATA_WIDTH  program-memory write data
- o_mem_we  out  1  program-memory write enable, one cycle per word
- o_cpu_rst  out  1  active-low reset to the CPU; 0 while loading
- o_loaded  out  1  program loaded and CPU running
- o_word_count  out  ADDR_WIDTH+1  number of words written in the current load
- o_overrun  out  1  sticky flag; a byte was dropped

Behaviour:
- All outputs are registered.
- Reset values (rst=0 at a clk edge):
  - state IDLE
  - o_mem_addr=0, o_mem_data=0, o_mem_we=0
  - o_cpu_rst=0, o_loaded=0, o_word_count=0, o_overrun=0
  - byte holding register=0
- FSM states: IDLE, WAIT_HI, WAIT_LO, WRITE, RUN.
- IDLE:
  - i_rx_valid is ignored.
  - On i_start: go to WAIT_HI; clear o_mem_addr, o_word_count and o_overrun.
- WAIT_HI:
  - On i_rx_valid: latch i_rx_data into hi_byte; go to WAIT_LO.
- WAIT_LO:
  - On i_rx_valid: o_mem_data <= {hi_byte, i_rx_data}; go to WRITE.
- WRITE (exactly 1 cycle):
  - o_mem_we=1 with the current o_mem_addr and o_mem_data.
  - o_word_count increments by 1 at the end of the cycle.
  - Next state:
    - If o_mem_data opcode == HLT_OPCODE, or o_mem_addr == 2^ADDR_WIDTH-1: go to RUN. o_mem_addr is not incremented.
    - Otherwise: o_mem_addr increments by 1; go to WAIT_HI.
- RUN:
  - o_cpu_rst=1 and o_loaded=1, both registered on entry.
  - i_rx_valid is ignored.
  - On i_start: go to WAIT_HI; o_cpu_rst=0 and o_loaded=0 on the next cycle; clear addr/count/overrun.
- o_cpu_rst is 0 in every state except RUN.
- Latency: the write is asserted 1 cycle after the low-byte strobe. o_cpu_rst rises 1 cycle after the final WRITE cycle.
- Overrun: i_rx_valid in the WRITE state drops the byte and sets o_overrun=1. The flag clears only on reset or i_start.
- i_start in WAIT_HI, WAIT_LO or WRITE restarts the load:
  - go to WAIT_HI; clear addr, count, overrun and hi_byte.
  - any pending write is aborted (o_mem_we=0 next cycle).
  - i_start has priority over i_rx_valid in the same cycle.
- Memory full: the word at address 2^ADDR_WIDTH-1 is written, then the block enters RUN even without HLT. o_word_count = 2^ADDR_WIDTH, which is why it is ADDR_WIDTH+1 bits wide.
- Reset mid-load: returns to IDLE, the CPU is held in reset, and partially written memory contents are left as they are.
- o_mem_data holds its last value outside WRITE. o_mem_we is the only qualifier.

Decomposition:
- Shared BIP package holds:
  - opcode width and the HLT opcode constant, shared with the instruction decoder
  - ADDR_WIDTH/DATA_WIDTH defaults
  - loader state encoding (localparams)
- No sub-module needed; a single FSM plus datapath registers. The byte-to-word assembler stays inline.

Test Plan:
- Reset then idle: hold rst=0 for 2 cycles, release, send bytes with no i_start -> o_mem_we never asserts, o_cpu_rst=0, o_word_count=0.
- Basic load: i_start, then bytes 0x08,0x05, 0x10,0x03, 0x00,0x00 ->
  - writes (addr 0, 0x0805), (1, 0x1003), (2, 0x0000), each o_mem_we exactly 1 cycle after its low-byte strobe
  - o_cpu_rst=1 and o_loaded=1 one cycle after the third write
  - o_word_count=3
- Overrun: strobe i_rx_valid on the cycle after a low byte (the WRITE cycle) -> byte dropped, o_overrun=1, next write still at addr+1 using the following two bytes.
- Restart mid-word: i_start after only the high byte 0xAB -> no write; the next pair 0x12,0x34 writes 0x1234 at addr 0.
- Memory full (ADDR_WIDTH=3): send 8 non-HLT words (opcode 0x01) -> writes at addr 0..7, RUN entered after addr 7, o_word_count=8.
- Reload from RUN: i_start while o_loaded=1 -> o_cpu_rst=0 and o_loaded=0 next cycle; new program written from addr 0.
